// File: rtl/banked_mem_responder.sv
// Four-bank interleaved word memory for the cache miss path: per-bank occupancy
// timers, same-cycle stall/err decode and a fixed-latency read return pipeline.
module banked_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MEM_WORDS   = 1024,
  parameter int BANK_CYCLES = 4,
  parameter int RD_LAT      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int CNT_W  = $clog2(BANK_CYCLES);
  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam logic [ADDR_W:0] MEM_WORDS_EXT = (ADDR_W+1)'(MEM_WORDS);

  logic [ADDR_W-2:0] word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic [1:0]        bank;
  logic              req;
  logic              in_range;
  logic              illegal;
  logic              accept;

  logic [CNT_W-1:0]  cnt [4];
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [RD_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0] pipe_dat [RD_LAT];

  assign word_idx = addr[ADDR_W-1:1];
  assign mem_idx  = word_idx[MEM_AW-1:0];
  assign bank     = addr[2:1];
  assign req      = rd | wr;
  assign in_range = {2'b00, word_idx} < MEM_WORDS_EXT;
  assign illegal  = (rd & wr) | addr[0] | ~in_range;

  // err masks stall, so a rejected request never looks like a retryable one
  assign err    = req & illegal;
  assign stall  = req & ~illegal & busy[bank];
  assign accept = req & ~illegal & ~busy[bank];

  always_comb begin
    busy = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      busy[b] = (cnt[b] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (accept && (bank == 2'(b))) begin
          cnt[b] <= CNT_W'(BANK_CYCLES - 1);
        end else if (cnt[b] != '0) begin
          cnt[b] <= cnt[b] - CNT_W'(1);
        end
      end
    end
  end

  // Storage has no reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (rst_n && accept && wr) begin
      mem[mem_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= accept & rd;
      pipe_dat[0] <= mem[mem_idx];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign data_out = pipe_vld[RD_LAT-1] ? pipe_dat[RD_LAT-1] : '0;

endmodule
